// File: rtl/whack_hit_if.sv
// Hit-event channel between the input encoder (master) and the game FSM (slave).
interface whack_hit_if;
  // A transfer happens on a Clk edge where hit_valid && hit_ready. While hit_valid is high
  // and hit_ready is low, hit_idx holds its value. hit_ready while hit_valid is low does nothing.
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_idx;

  modport master (output hit_valid, output hit_idx, input hit_ready);
  modport slave  (input hit_valid, input hit_idx, output hit_ready);
endinterface

// File: rtl/whack_input_encoder.sv
// Synchronise/debounce 9 hit switches and 4 buttons, encode switch rises into indexed hits.
// Optional macro WHACK_HIT_FIFO_EN replaces the single-entry hit register with a FIFO_DEPTH FIFO.
module whack_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [8:0]  Sw,
  input  logic        BtnC,
  input  logic        BtnU,
  input  logic        BtnL,
  input  logic        BtnR,
  whack_hit_if.master hit,
  output logic [3:0]  btn_pulse,
  output logic        multi_sw,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  fsm_state
);

  localparam int NIN = 13;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  // Bits [8:0] are the switches, [12:9] the buttons in {C,U,L,R} order.
  logic [NIN-1:0]            raw;
  logic [NIN-1:0]            sync1_q, sync2_q;
  logic [NIN-1:0]            stable_q, stable_d, stable_prev_q;
  logic [NIN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NIN-1:0]            rise;

  assign raw = {BtnC, BtnU, BtnL, BtnR, Sw};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  logic [3:0] win_idx, n_rise, n_high, n_drop;
  logic       any_rise, lost;
  logic [8:0] drop_sum;

  always_comb begin
    win_idx = '0;
    n_rise  = '0;
    n_high  = '0;
    for (int i = 8; i >= 0; i--) begin
      if (rise[i]) win_idx = 4'(i);
      n_rise = n_rise + 4'(rise[i]);
      n_high = n_high + 4'(stable_q[i]);
    end
  end

  assign any_rise = |rise[8:0];
  // Losers of a same-cycle collision plus the winner itself when it has nowhere to go.
  assign n_drop   = (any_rise ? n_rise - 4'd1 : 4'd0) + {3'd0, lost};
  assign drop_sum = {1'b0, drop_cnt} + 9'(n_drop);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drop_cnt  <= '0;
      btn_pulse <= '0;
      multi_sw  <= 1'b0;
    end else begin
      drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      btn_pulse <= rise[12:9];
      multi_sw  <= (n_high > 4'd1);
    end
  end

`ifdef WHACK_HIT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, count;
  logic        empty, full, push, pop;

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = !empty && hit.hit_ready;
  // A full FIFO still accepts a push in the same cycle as a pop.
  assign push  = any_rise && (!full || pop);
  assign lost  = any_rise && full && !pop;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= win_idx;
  end

  assign hit.hit_valid = !empty;
  assign hit.hit_idx   = empty ? 4'd0 : mem_q[rd_q[AW-1:0]];
  assign fsm_state     = {full, !empty};
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1} state_e;

  state_e     state_q;
  logic [3:0] idx_q;

  assign lost = any_rise && (state_q == ST_FULL) && !hit.hit_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (any_rise) begin
            state_q <= ST_FULL;
            idx_q   <= win_idx;
          end
        end
        ST_FULL: begin
          if (hit.hit_ready) begin
            if (any_rise) idx_q <= win_idx;
            else          state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign hit.hit_valid = (state_q == ST_FULL);
  assign hit.hit_idx   = idx_q;
  assign fsm_state     = state_q;
`endif

endmodule

// File: tb/tb_whack_input_encoder.sv
// Directed bench for whack_input_encoder with DEBOUNCE_CYCLES=4 (raw edge to hit_valid = 7 edges).
module tb_whack_input_encoder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [8:0] Sw;
  logic       BtnC, BtnU, BtnL, BtnR;
  logic [3:0] btn_pulse;
  logic       multi_sw;
  logic [7:0] drop_cnt;
  logic [1:0] fsm_state;
  int         checks = 0;
  int         errors = 0;

  whack_hit_if hit_if ();

  always #5 Clk = ~Clk;

  whack_input_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sw(Sw), .BtnC(BtnC), .BtnU(BtnU), .BtnL(BtnL), .BtnR(BtnR),
    .hit(hit_if), .btn_pulse(btn_pulse), .multi_sw(multi_sw), .drop_cnt(drop_cnt),
    .fsm_state(fsm_state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    Sw = '0; BtnC = 0; BtnU = 0; BtnL = 0; BtnR = 0;
    hit_if.hit_ready = 1'b0;
    tick(2);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    Sw = 9'h1FF;
    tick(7);
    checks++; if (hit_if.hit_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %0b exp 1", hit_if.hit_valid); end
    checks++; if (drop_cnt !== 8'd8) begin errors++; $display("FAIL pre_rst_drop got %0d exp 8", drop_cnt); end
    checks++; if (multi_sw !== 1'b1) begin errors++; $display("FAIL pre_rst_multi got %0b exp 1", multi_sw); end
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL pre_rst_state got %0d exp 1", fsm_state); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (hit_if.hit_valid !== 1'b0 || hit_if.hit_idx !== 4'd0) begin errors++; $display("FAIL async_rst_hit got v%0b i%0d exp v0 i0", hit_if.hit_valid, hit_if.hit_idx); end
    checks++; if (drop_cnt !== 8'd0 || multi_sw !== 1'b0 || btn_pulse !== 4'd0) begin errors++; $display("FAIL async_rst_misc got d%0d m%0b b%0h exp 0", drop_cnt, multi_sw, btn_pulse); end
    tick(1);
    Reset_n = 1'b1;
    tick(6);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL rel_early_valid got %0b exp 0", hit_if.hit_valid); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd0) begin errors++; $display("FAIL rel_hit got v%0b i%0d exp v1 i0", hit_if.hit_valid, hit_if.hit_idx); end
    checks++; if (drop_cnt !== 8'd8) begin errors++; $display("FAIL rel_drop got %0d exp 8", drop_cnt); end
    hit_if.hit_ready = 1'b1;
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL rel_consume got %0b exp 0", hit_if.hit_valid); end
  endtask

  task automatic test_single_hit();
    logic seen;
    apply_reset();
    hit_if.hit_ready = 1'b1;
    Sw[5] = 1'b1;
    tick(6);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", hit_if.hit_valid); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd5) begin errors++; $display("FAIL single_hit got v%0b i%0d exp v1 i5", hit_if.hit_valid, hit_if.hit_idx); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b exp 0", hit_if.hit_valid); end
    Sw[5] = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(1); if (hit_if.hit_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL falling_event got %0b exp 0", seen); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL single_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_glitch();
    logic seen;
    apply_reset();
    hit_if.hit_ready = 1'b1;
    Sw[3] = 1'b1;
    tick(3);
    Sw[3] = 1'b0;
    seen = 1'b0;
    repeat (15) begin tick(1); if (hit_if.hit_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_valid got %0b exp 0", seen); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL glitch_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_hold_drop();
    apply_reset();
    Sw[2] = 1'b1;
    tick(7);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd2) begin errors++; $display("FAIL hold_first got v%0b i%0d exp v1 i2", hit_if.hit_valid, hit_if.hit_idx); end
    tick(13);
    Sw[7] = 1'b1;
    tick(7);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd2) begin errors++; $display("FAIL hold_kept got v%0b i%0d exp v1 i2", hit_if.hit_valid, hit_if.hit_idx); end
`ifdef WHACK_HIT_FIFO_EN
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL hold_drop got %0d exp 0", drop_cnt); end
    hit_if.hit_ready = 1'b1;
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd7) begin errors++; $display("FAIL hold_second got v%0b i%0d exp v1 i7", hit_if.hit_valid, hit_if.hit_idx); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %0b exp 0", hit_if.hit_valid); end
`else
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL hold_drop got %0d exp 1", drop_cnt); end
    hit_if.hit_ready = 1'b1;
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %0b exp 0", hit_if.hit_valid); end
`endif
    hit_if.hit_ready = 1'b0;
  endtask

  task automatic test_button_multi();
    int extra;
    apply_reset();
    hit_if.hit_ready = 1'b1;
    BtnL = 1'b1;
    Sw[1] = 1'b1;
    Sw[4] = 1'b1;
    tick(6);
    checks++; if (btn_pulse !== 4'b0000 || multi_sw !== 1'b0) begin errors++; $display("FAIL btn_early got b%b m%0b exp b0000 m0", btn_pulse, multi_sw); end
    tick(1);
    checks++; if (btn_pulse !== 4'b0010) begin errors++; $display("FAIL btn_pulse got %b exp 0010", btn_pulse); end
    checks++; if (multi_sw !== 1'b1) begin errors++; $display("FAIL multi_sw got %0b exp 1", multi_sw); end
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd1) begin errors++; $display("FAIL collide_idx got v%0b i%0d exp v1 i1", hit_if.hit_valid, hit_if.hit_idx); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL collide_drop got %0d exp 1", drop_cnt); end
    extra = 0;
    repeat (93) begin tick(1); if (btn_pulse !== 4'b0000) extra++; end
    BtnL = 1'b0;
    Sw = '0;
    repeat (10) begin tick(1); if (btn_pulse !== 4'b0000) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL btn_repeat got %0d exp 0", extra); end
    checks++; if (multi_sw !== 1'b0) begin errors++; $display("FAIL multi_clear got %0b exp 0", multi_sw); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    hit_if.hit_ready = 1'b1;
    Sw[6] = 1'b1;
    tick(1);
    Sw[0] = 1'b1;
    tick(6);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd6) begin errors++; $display("FAIL b2b_first got v%0b i%0d exp v1 i6", hit_if.hit_valid, hit_if.hit_idx); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd0) begin errors++; $display("FAIL b2b_second got v%0b i%0d exp v1 i0", hit_if.hit_valid, hit_if.hit_idx); end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_end got v%0b d%0d exp v0 d0", hit_if.hit_valid, drop_cnt); end
  endtask

  task automatic test_saturate();
    apply_reset();
    hit_if.hit_ready = 1'b1;
    for (int p = 0; p < 33; p++) begin
      Sw = 9'h1FF;
      tick(8);
      Sw = 9'h000;
      tick(8);
      if (p == 30) begin
        checks++; if (drop_cnt !== 8'd248) begin errors++; $display("FAIL sat_before got %0d exp 248", drop_cnt); end
      end
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", drop_cnt); end
  endtask

`ifdef WHACK_HIT_FIFO_EN
  task automatic test_fifo();
    logic [3:0] exp_seq [4] = '{4'd2, 4'd3, 4'd8, 4'd0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      Sw[i] = 1'b1;
      tick(2);
    end
    tick(10);
    checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== 4'd0) begin errors++; $display("FAIL fifo_head got v%0b i%0d exp v1 i0", hit_if.hit_valid, hit_if.hit_idx); end
    checks++; if (drop_cnt !== 8'd1 || fsm_state !== 2'b11) begin errors++; $display("FAIL fifo_full got d%0d s%b exp d1 s11", drop_cnt, fsm_state); end
    Sw[8] = 1'b1;
    tick(6);
    hit_if.hit_ready = 1'b1;
    tick(1);
    checks++; if (hit_if.hit_idx !== 4'd1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL fifo_pushpop got i%0d d%0d exp i1 d1", hit_if.hit_idx, drop_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (hit_if.hit_valid !== 1'b1 || hit_if.hit_idx !== exp_seq[i]) begin errors++; $display("FAIL fifo_order got v%0b i%0d exp v1 i%0d", hit_if.hit_valid, hit_if.hit_idx, exp_seq[i]); end
    end
    tick(1);
    checks++; if (hit_if.hit_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got %0b exp 0", hit_if.hit_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_glitch();
    test_hold_drop();
    test_button_multi();
    test_back_to_back();
    test_saturate();
`ifdef WHACK_HIT_FIFO_EN
    test_fifo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
